button_event_gen: RTL and testbench



---
 rtl/button_event_gen.sv | 189 ++++++++++++++++++
 tb/tb_button_event_gen.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/button_event_gen.sv
// Push-button front-end: 2-flop synchronizer, debounce FSM and one-cycle press/release/long/repeat pulses.
// Optional auto-repeat is enabled by defining BUTTON_EVENT_REPEAT_EN; otherwise repeat_pulse is tied to 0.
module button_event_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned LONG_CYCLES     = 25_000_000,
    parameter int unsigned REPEAT_CYCLES   = 5_000_000,
    parameter bit          ACTIVE_HIGH     = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic held,
    output logic press,
    output logic release_pulse,
    output logic long_press,
    output logic repeat_pulse
);

    localparam int unsigned CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HOLD_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic PAD_IDLE = ACTIVE_HIGH ? 1'b0 : 1'b1;

    if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
        $error("button_event_gen: cycle parameters must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEB_PRESS,
        S_PRESSED,
        S_LONG_HELD,
        S_DEB_RELEASE
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
    logic                from_long, from_long_nxt;
    logic                sync1, sync2;
    logic                lvl;
    logic                held_c, press_c, release_c, long_c;

    // Pad synchronizer, reset to the released pad level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= PAD_IDLE;
            sync2 <= PAD_IDLE;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    assign lvl = ACTIVE_HIGH ? sync2 : ~sync2;

`ifdef BUTTON_EVENT_REPEAT_EN
    localparam int unsigned REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] rep_cnt, rep_nxt;
    logic             repeat_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt      <= '0;
            repeat_pulse <= 1'b0;
        end else begin
            rep_cnt      <= rep_nxt;
            repeat_pulse <= repeat_c;
        end
    end
`else
    assign repeat_pulse = 1'b0;
`endif

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cnt           <= '0;
            hold_cnt      <= '0;
            from_long     <= 1'b0;
            held          <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            hold_cnt      <= hold_nxt;
            from_long     <= from_long_nxt;
            held          <= held_c;
            press         <= press_c;
            release_pulse <= release_c;
            long_press    <= long_c;
        end
    end

    // Next state; a low level always wins over a long/repeat terminal count
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        hold_nxt      = hold_cnt;
        from_long_nxt = from_long;
`ifdef BUTTON_EVENT_REPEAT_EN
        rep_nxt       = rep_cnt;
`endif
        unique case (state)
            S_IDLE: begin
                if (lvl) begin
                    state_nxt = S_DEB_PRESS;
                    cnt_nxt   = '0;
                end
            end
            S_DEB_PRESS: begin
                if (!lvl) begin
                    state_nxt = S_IDLE;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = S_PRESSED;
                    hold_nxt  = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_PRESSED: begin
                if (!lvl) begin
                    state_nxt     = S_DEB_RELEASE;
                    cnt_nxt       = '0;
                    from_long_nxt = 1'b0;
                end else if (hold_cnt == LONG_LAST) begin
                    state_nxt = S_LONG_HELD;
`ifdef BUTTON_EVENT_REPEAT_EN
                    rep_nxt   = '0;
`endif
                end else begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            S_LONG_HELD: begin
                if (!lvl) begin
                    state_nxt     = S_DEB_RELEASE;
                    cnt_nxt       = '0;
                    from_long_nxt = 1'b1;
                end else begin
`ifdef BUTTON_EVENT_REPEAT_EN
                    if (rep_cnt == REP_LAST) begin
                        rep_nxt = '0;
                    end else begin
                        rep_nxt = rep_cnt + REP_W'(1);
                    end
`endif
                end
            end
            S_DEB_RELEASE: begin
                // Hold/repeat counters stay frozen here and resume on a bounce back
                if (lvl) begin
                    state_nxt = from_long ? S_LONG_HELD : S_PRESSED;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode from the transition being taken
    always_comb begin
        held_c    = 1'b0;
        press_c   = 1'b0;
        release_c = 1'b0;
        long_c    = 1'b0;
        held_c    = (state_nxt == S_PRESSED) || (state_nxt == S_LONG_HELD) ||
                    (state_nxt == S_DEB_RELEASE);
        press_c   = (state == S_DEB_PRESS) && (state_nxt == S_PRESSED);
        release_c = (state == S_DEB_RELEASE) && (state_nxt == S_IDLE);
        long_c    = (state == S_PRESSED) && (state_nxt == S_LONG_HELD);
`ifdef BUTTON_EVENT_REPEAT_EN
        repeat_c  = 1'b0;
        repeat_c  = (state == S_LONG_HELD) && lvl && (rep_cnt == REP_LAST);
`endif
    end

endmodule

// File: tb/tb_button_event_gen.sv
// Bench for button_event_gen: an active-high and an active-low instance see the same logical
// button and are compared every cycle against a run-length model, plus segment tables and corner cases.
`timescale 1ns/1ps
module tb_button_event_gen;

    localparam int unsigned D = 4;
    localparam int unsigned L = 20;
    localparam int unsigned R = 5;
`ifdef BUTTON_EVENT_REPEAT_EN
    localparam int REP_ON = 1;
`else
    localparam int REP_ON = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic din = 1'b0;
    logic din_b;
    logic held_a, press_a, rel_a, long_a, rep_a;
    logic held_b, press_b, rel_b, long_b, rep_b;

    assign din_b = ~din;

    button_event_gen #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .REPEAT_CYCLES(R), .ACTIVE_HIGH(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .din(din), .held(held_a), .press(press_a),
        .release_pulse(rel_a), .long_press(long_a), .repeat_pulse(rep_a));

    button_event_gen #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .REPEAT_CYCLES(R), .ACTIVE_HIGH(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .din(din_b), .held(held_b), .press(press_b),
        .release_pulse(rel_b), .long_press(long_b), .repeat_pulse(rep_b));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_press, n_rel, n_long, n_rep;

    // Reference: debounced level plus run-length counters, outputs {held,press,release,long,repeat}
    bit p1, p2;
    bit m_down, m_long;
    int m_run, m_hold, m_rep;
    logic [4:0] m_out;

    task automatic model_reset();
        p1 = 0; p2 = 0; m_down = 0; m_long = 0;
        m_run = 0; m_hold = 0; m_rep = 0; m_out = 5'b0;
    endtask

    task automatic model_edge(input bit pressed_now);
        bit lvl;
        lvl = p2;
        p2 = p1;
        p1 = pressed_now;
        m_out = 5'b0;
        if (!m_down) begin
            if (lvl) begin
                m_run++;
                if (m_run == int'(D) + 1) begin
                    m_down = 1; m_run = 0; m_hold = 0; m_long = 0; m_rep = 0;
                    m_out[3] = 1'b1;
                end
            end else begin
                m_run = 0;
            end
        end else if (!lvl) begin
            m_run++;
            if (m_run == int'(D) + 1) begin
                m_down = 0; m_run = 0;
                m_out[2] = 1'b1;
            end
        end else if (m_run > 0) begin
            m_run = 0;
        end else if (!m_long) begin
            m_hold++;
            if (m_hold == int'(L)) begin
                m_long = 1; m_rep = 0;
                m_out[1] = 1'b1;
            end
        end else if (REP_ON != 0) begin
            m_rep++;
            if (m_rep == int'(R)) begin
                m_rep = 0;
                m_out[0] = 1'b1;
            end
        end
        m_out[4] = m_down;
    endtask

    task automatic cmp_outs(input string tag, input logic [4:0] exp);
        logic [4:0] a, b;
        a = {held_a, press_a, rel_a, long_a, rep_a};
        b = {held_b, press_b, rel_b, long_b, rep_b};
        checks++;
        if (a !== exp) begin
            errors++;
            $display("FAIL %s active_high cycle %0d got %b want %b (held,press,rel,long,rep)", tag, cyc, a, exp);
        end
        checks++;
        if (b !== exp) begin
            errors++;
            $display("FAIL %s active_low cycle %0d got %b want %b (held,press,rel,long,rep)", tag, cyc, b, exp);
        end
    endtask

    task automatic tick(input logic d, input string tag);
        din = d;
        @(posedge clk);
        cyc++;
        model_edge(d);
        #1;
        cmp_outs(tag, m_out);
        n_press += int'(press_a);
        n_rel   += int'(rel_a);
        n_long  += int'(long_a);
        n_rep   += int'(rep_a);
    endtask

    typedef struct {
        logic d;
        int   len;
        int   e_press;
        int   e_rel;
        int   e_long;
        int   e_rep;
        logic e_held;
    } seg_t;

    seg_t segs[19];

    initial begin
        // Clean press, long hold, repeat, release glitch, release, bounce, stable press, release
        segs[0] = '{1'b1, 7,  1, 0, 0, 0,          1'b1};
        segs[1] = '{1'b1, 20, 0, 0, 1, 0,          1'b1};
        segs[2] = '{1'b1, 10, 0, 0, 0, 2 * REP_ON, 1'b1};
        segs[3] = '{1'b0, 3,  0, 0, 0, 0,          1'b1};
        segs[4] = '{1'b1, 10, 0, 0, 0, REP_ON,     1'b1};
        segs[5] = '{1'b0, 7,  0, 1, 0, REP_ON,     1'b0};
        for (int i = 0; i < 5; i++) begin
            segs[6 + 2 * i] = '{1'b1, 3, 0, 0, 0, 0, 1'b0};
            segs[7 + 2 * i] = '{1'b0, 1, 0, 0, 0, 0, 1'b0};
        end
        segs[16] = '{1'b1, 6, 0, 0, 0, 0, 1'b0};
        segs[17] = '{1'b1, 1, 1, 0, 0, 0, 1'b1};
        segs[18] = '{1'b0, 7, 0, 1, 0, 0, 1'b0};

        model_reset();
        rst_n = 1'b0;
        din = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cmp_outs("reset_state", 5'b0);
        rst_n = 1'b1;

        foreach (segs[i]) begin
            n_press = 0; n_rel = 0; n_long = 0; n_rep = 0;
            for (int k = 0; k < segs[i].len; k++) tick(segs[i].d, "table_cycle");
            checks++;
            if (n_press != segs[i].e_press || n_rel != segs[i].e_rel || n_long != segs[i].e_long ||
                n_rep != segs[i].e_rep || held_a !== segs[i].e_held) begin
                errors++;
                $display("FAIL segment_%0d got press=%0d rel=%0d long=%0d rep=%0d held=%b want %0d %0d %0d %0d %b",
                         i, n_press, n_rel, n_long, n_rep, held_a,
                         segs[i].e_press, segs[i].e_rel, segs[i].e_long, segs[i].e_rep, segs[i].e_held);
            end
        end

        // Reset during a long hold: outputs clear asynchronously, no release, then a fresh press
        for (int k = 0; k < 30; k++) tick(1'b1, "to_long_hold");
        checks++;
        if (held_a !== 1'b1 || held_b !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_held got %b/%b want 1", held_a, held_b);
        end
        rst_n = 1'b0;
        #1;
        cmp_outs("async_reset", 5'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            cmp_outs("in_reset", 5'b0);
        end
        model_reset();
        rst_n = 1'b1;
        n_press = 0; n_rel = 0;
        for (int k = 0; k < 6; k++) tick(1'b1, "post_reset");
        checks++;
        if (n_press != 0 || n_rel != 0) begin
            errors++;
            $display("FAIL post_reset_early got press=%0d rel=%0d want 0 0", n_press, n_rel);
        end
        tick(1'b1, "post_reset");
        checks++;
        if (press_a !== 1'b1 || press_b !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_press got %b/%b want 1", press_a, press_b);
        end
        for (int k = 0; k < 10; k++) tick(1'b0, "post_reset_rel");

        // Randomised runs of each level against the model
        for (int blk = 0; blk < 200; blk++) begin
            logic v;
            int len;
            v = 1'($urandom_range(1, 0));
            len = (($urandom_range(3, 0)) == 0) ? int'($urandom_range(60, 20)) : int'($urandom_range(8, 1));
            for (int k = 0; k < len; k++) tick(v, "random");
        end
        for (int k = 0; k < 12; k++) tick(1'b0, "random_drain");
        checks++;
        if (held_a !== 1'b0 || held_b !== 1'b0) begin
            errors++;
            $display("FAIL final_idle got %b/%b want 0", held_a, held_b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
